// File: rtl/wash_seq_ctrl.sv
// Wash-cycle sequencer: FILL -> WASH -> DRAIN -> N x RINSE -> SPIN, with door
// interlock, pause/resume on a frozen timer, and abort-with-drain.
module wash_seq_ctrl #(
   parameter int CNT_W   = 8,
   parameter int FILL_T  = 10,
   parameter int WASH_T  = 20,
   parameter int DRAIN_T = 8,
   parameter int RINSE_T = 6,
   parameter int SPIN_T  = 12,
   parameter int RINSE_W = 3
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic               pause,
   input  logic               abort,
   input  logic               door_open,
   input  logic [RINSE_W-1:0] rinse_cnt,
   output logic [2:0]         stage,
   output logic               busy,
   output logic               paused,
   output logic               done,
   output logic               aborted,
   output logic               input_valve,
   output logic               output_drain,
   output logic               motor
);

   typedef enum logic [2:0] {
      ST_FILL  = 3'b000,
      ST_WASH  = 3'b001,
      ST_DRAIN = 3'b010,
      ST_RINSE = 3'b011,
      ST_SPIN  = 3'b100,
      ST_ABORT = 3'b101,
      ST_IDLE  = 3'b111
   } stage_e;

   // Terminal timer values; a stage of length T ends when timer == T-1.
   localparam logic [CNT_W-1:0] FILL_LAST  = CNT_W'(FILL_T - 1);
   localparam logic [CNT_W-1:0] WASH_LAST  = CNT_W'(WASH_T - 1);
   localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_T - 1);
   localparam logic [CNT_W-1:0] RINSE_LAST = CNT_W'(RINSE_T - 1);
   localparam logic [CNT_W-1:0] SPIN_LAST  = CNT_W'(SPIN_T - 1);

   // Stage register is a plain vector so illegal codes stay representable
   // and can be recovered from.
   logic [2:0]         stage_reg, stage_next;
   logic [CNT_W-1:0]   timer_reg, timer_next;
   logic [RINSE_W-1:0] rinse_left_reg, rinse_left_next;
   logic               rphase_reg, rphase_next;
   logic               done_reg, done_next;
   logic               aborted_reg, aborted_next;

   logic               running;
   logic               held;
   logic [CNT_W-1:0]   stage_last;
   logic               timer_end;

   always_ff @(posedge clk) begin
      if (reset) begin
         stage_reg      <= ST_IDLE;
         timer_reg      <= '0;
         rinse_left_reg <= '0;
         rphase_reg     <= 1'b0;
         done_reg       <= 1'b0;
         aborted_reg    <= 1'b0;
      end else begin
         stage_reg      <= stage_next;
         timer_reg      <= timer_next;
         rinse_left_reg <= rinse_left_next;
         rphase_reg     <= rphase_next;
         done_reg       <= done_next;
         aborted_reg    <= aborted_next;
      end
   end

   always_comb begin
      running    = 1'b0;
      stage_last = '0;
      case (stage_reg)
         ST_FILL:  begin running = 1'b1; stage_last = FILL_LAST;  end
         ST_WASH:  begin running = 1'b1; stage_last = WASH_LAST;  end
         ST_DRAIN: begin running = 1'b1; stage_last = DRAIN_LAST; end
         ST_RINSE: begin running = 1'b1; stage_last = RINSE_LAST; end
         ST_SPIN:  begin running = 1'b1; stage_last = SPIN_LAST;  end
         ST_ABORT: stage_last = DRAIN_LAST;
         default:  stage_last = '0;
      endcase
   end

   assign held      = pause | door_open;
   assign timer_end = (timer_reg == stage_last);

   always_comb begin
      stage_next      = stage_reg;
      timer_next      = timer_reg;
      rinse_left_next = rinse_left_reg;
      rphase_next     = rphase_reg;
      done_next       = 1'b0;
      aborted_next    = 1'b0;
      case (stage_reg)
         ST_IDLE: begin
            if (start && !door_open) begin
               stage_next      = ST_FILL;
               timer_next      = '0;
               rinse_left_next = rinse_cnt;
               rphase_next     = 1'b0;
            end
         end
         ST_FILL, ST_WASH, ST_DRAIN, ST_RINSE, ST_SPIN: begin
            if (abort) begin
               stage_next = ST_ABORT;
               timer_next = '0;
            end else if (!held) begin
               if (!timer_end) begin
                  timer_next = timer_reg + CNT_W'(1);
               end else begin
                  timer_next = '0;
                  case (stage_reg)
                     ST_FILL:  stage_next = ST_WASH;
                     ST_WASH:  stage_next = ST_DRAIN;
                     ST_DRAIN: stage_next = (rinse_left_reg != '0) ? ST_RINSE : ST_SPIN;
                     ST_RINSE: begin
                        if (!rphase_reg) begin
                           rphase_next = 1'b1;
                        end else begin
                           rphase_next     = 1'b0;
                           rinse_left_next = rinse_left_reg - RINSE_W'(1);
                           if (rinse_left_reg == RINSE_W'(1))
                              stage_next = ST_SPIN;
                        end
                     end
                     ST_SPIN: begin
                        stage_next = ST_IDLE;
                        done_next  = 1'b1;
                     end
                     default:  stage_next = ST_IDLE;
                  endcase
               end
            end
         end
         ST_ABORT: begin
            // Drain runs to completion regardless of panel inputs.
            if (timer_end) begin
               stage_next   = ST_IDLE;
               timer_next   = '0;
               aborted_next = 1'b1;
            end else begin
               timer_next = timer_reg + CNT_W'(1);
            end
         end
         default: begin
            stage_next      = ST_IDLE;
            timer_next      = '0;
            rinse_left_next = '0;
            rphase_next     = 1'b0;
         end
      endcase
   end

   assign stage   = stage_reg;
   assign busy    = (stage_reg != ST_IDLE);
   assign paused  = running & held;
   assign done    = done_reg;
   assign aborted = aborted_reg;

   always_comb begin
      input_valve  = 1'b0;
      output_drain = 1'b0;
      motor        = 1'b0;
      if (!paused) begin
         case (stage_reg)
            ST_FILL:  input_valve = 1'b1;
            ST_WASH:  motor = 1'b1;
            ST_DRAIN: output_drain = 1'b1;
            ST_RINSE: begin
               input_valve  = ~rphase_reg;
               output_drain = rphase_reg;
            end
            ST_SPIN: begin
               output_drain = 1'b1;
               motor        = 1'b1;
            end
            ST_ABORT: output_drain = 1'b1;
            default: begin
               input_valve  = 1'b0;
               output_drain = 1'b0;
               motor        = 1'b0;
            end
         endcase
      end
   end

endmodule

// File: doc/wash_seq_ctrl.md
# wash_seq_ctrl

Parametrised wash-cycle sequencer: the next-generation appliance controller FSM. It sequences FILL → WASH → DRAIN → N×RINSE → SPIN with per-stage durations set by parameters and a rinse count latched at start. It adds door interlock, pause/resume with a frozen timer, and abort-with-drain, and it drives the valve, drain and motor actuators. It sits between the front-panel/button logic and the actuator drivers.

## Interface
- CNT_W, 8: stage timer width; every *_T value must satisfy 1 ≤ T ≤ 2^CNT_W.
- FILL_T, 10: FILL duration in clk cycles.
- WASH_T, 20: WASH duration.
- DRAIN_T, 8: DRAIN duration; also the ABORT drain duration.
- RINSE_T, 6: duration of each rinse sub-phase (fill, then drain).
- SPIN_T, 12: SPIN duration.
- RINSE_W, 3: width of rinse_cnt.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  level; sampled only in IDLE.
- pause  in  1  level; holds the cycle while high.
- abort  in  1  level; sampled every cycle while busy.
- door_open  in  1  interlock; blocks start; auto-pauses while running.
- rinse_cnt  in  RINSE_W  number of rinse iterations; latched on start.
- stage  out  3  current stage encoding.
- busy  out  1  high in any stage other than IDLE.
- paused  out  1  high while busy and held (pause or door_open), excluding ABORT.
- done  out  1  one-cycle pulse on normal completion.
- aborted  out  1  one-cycle pulse when the ABORT drain ends.
- input_valve  out  1  water inlet.
- output_drain  out  1  drain pump.
- motor  out  1  drum motor.

## Operation
- Stage encodings: IDLE=3'b111, FILL=000, WASH=001, DRAIN=010, RINSE=011, SPIN=100, ABORT=101. Codes 110 and any other illegal value go to IDLE on the next clock.
- Internal registers:
  - timer[CNT_W-1:0]
  - rinse_left[RINSE_W-1:0]
  - rphase: 0 = rinse fill, 1 = rinse drain.
- Actuator decode is combinational from the registered stage, rphase and paused. It adds no latency.
  - IDLE: all 0.
  - FILL: valve=1.
  - WASH: motor=1.
  - DRAIN: drain=1.
  - RINSE: valve=1 when rphase=0; drain=1 when rphase=1.
  - SPIN: drain=1, motor=1.
  - ABORT: drain=1.
  - While paused=1: all three actuators are forced to 0.
- Priority, highest first: reset > abort > hold (pause | door_open) > timer advance.
- IDLE behaviour: if start=1 and door_open=0, then on the next clock stage=FILL, timer=0, rinse_left=rinse_cnt, rphase=0. Otherwise the block stays in IDLE. Pause and abort are ignored in IDLE.
- Running stages (FILL..SPIN):
  - When not held, timer increments each cycle.
  - When timer == T−1, the block moves to the next stage with timer=0.
- Stage successions:
  - FILL → WASH → DRAIN.
  - DRAIN → RINSE when rinse_left ≠ 0; DRAIN → SPIN when rinse_left = 0.
  - RINSE, rphase=0 ends: rphase becomes 1.
  - RINSE, rphase=1 ends: rinse_left decrements and rphase becomes 0. If the decremented value is 0, the block goes to SPIN; otherwise it stays in RINSE.
  - SPIN → IDLE, with done=1 for the first IDLE cycle.
- Hold: while busy in FILL..SPIN and (pause | door_open) is high:
  - timer, stage, rphase and rinse_left are frozen.
  - paused=1.
  - When the hold is released, the block resumes at the frozen timer value, so no cycles are lost or repeated.
- Abort: abort=1 in any running stage, including while held, gives stage=ABORT, timer=0 on the next clock.
  - ABORT runs DRAIN_T cycles and ignores pause, door_open, abort and start.
  - It then goes to IDLE with aborted=1 for one cycle. done stays 0.
- start while busy is ignored. rinse_cnt changes after start have no effect.

## Timing
- Reset values, taking effect at the clock edge where reset=1:
  - stage=IDLE, timer=0, rinse_left=0, rphase=0.
  - busy=0, paused=0, done=0, aborted=0.
  - All actuators 0.
- Reset mid-cycle, in any stage, returns to IDLE on the next edge with no done or aborted pulse.
- A stage with duration T shows its stage code for exactly T unheld cycles.
- Cycle counting: start sampled at edge 0 puts the block in FILL for cycles 1..FILL_T.
- Total unheld run length: L = FILL_T + WASH_T + DRAIN_T + 2·RINSE_T·rinse_cnt + SPIN_T. done is high in cycle L+1.
- Hold cycles add 1:1 to L.
- done and aborted are never high together, and each is high for exactly one cycle.
- A new start is accepted in the same cycle done is high, provided door_open=0.

## Test plan
Parameters for all tests unless stated otherwise: FILL_T=3, WASH_T=4, DRAIN_T=2, RINSE_T=2, SPIN_T=3.
- Nominal run: rinse_cnt=2, one-cycle start pulse at cycle 0.
  - Stage sequence: FILL cycles 1–3, WASH 4–7, DRAIN 8–9, RINSE 10–17 (valve/drain alternating every 2 cycles), SPIN 18–20.
  - done=1 only at cycle 21.
- Zero rinse: rinse_cnt=0 → DRAIN 8–9 goes directly to SPIN 10–12, done at cycle 13.
- Pause mid-WASH: assert pause for 5 cycles at cycle 5.
  - paused=1 and motor=0 for those 5 cycles, stage stays 001.
  - WASH then completes its remaining cycles; done arrives 5 cycles late, at cycle 26 with rinse_cnt=2.
- Door interlock:
  - door_open=1 with start=1 in IDLE → stays IDLE, busy=0.
  - door_open asserted during SPIN → paused=1 and actuators 0 until the door closes.
- Abort in RINSE: pulse abort at cycle 12 → ABORT with drain=1 for cycles 13–14, IDLE with aborted=1 at cycle 15, done never asserted.
- Reset and illegal state: reset at cycle 6 → all outputs at reset values at cycle 7. Force stage=3'b110 → IDLE on the next clock.
